// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_scheduler
//  Description : Selects which 32-bit word drives the LED display. A debounced
//                page button cycles SYSCALL -> CYCLES -> PC. A new syscall
//                value preempts the display for FLASH_CYCLES cycles. Optional
//                auto-rotation is enabled by DISPLAY_SCHEDULER_AUTO_ROTATE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module display_scheduler #(
    parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [23:0] FLASH_CYCLES    = 24'd5000000,
    parameter logic [27:0] ROTATE_CYCLES   = 28'd100000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] syscall_data,
    input  logic        syscall_valid,
    input  logic [11:0] cycles_counter,
    input  logic [31:0] pc,
    input  logic        btn_next,
    output logic [31:0] display_word,
    output logic [1:0]  page,
    output logic        page_changed
);

    typedef enum logic [1:0] {
        S_SYSCALL = 2'd0,
        S_CYCLES  = 2'd1,
        S_PC      = 2'd2,
        S_FLASH   = 2'd3
    } state_t;

    logic        r_sync1;
    logic        r_sync2;
    logic [19:0] r_db_cnt;
    logic        r_db_level;
    logic        r_db_prev;
    logic        w_press;

    state_t      r_state;
    state_t      w_next_state;
    state_t      r_saved_page;
    state_t      w_next_saved;
    logic [23:0] r_flash_cnt;
    logic [23:0] w_next_flash_cnt;
    logic [31:0] r_syscall_reg;
    logic        w_rotate_expire;

    // Normal-page successor; FLASH never appears as a saved page.
    function automatic state_t f_next_page(input state_t s);
        case (s)
            S_SYSCALL: f_next_page = S_CYCLES;
            S_CYCLES:  f_next_page = S_PC;
            default:   f_next_page = S_SYSCALL;
        endcase
    endfunction

    // Two-flop synchronizer for the raw button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_next;
            r_sync2 <= r_sync1;
        end
    end

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive mismatches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= 20'd0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
        end else begin
            r_db_prev <= r_db_level;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == DEBOUNCE_CYCLES - 20'd1) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= 20'd0;
                end else begin
                    r_db_cnt <= r_db_cnt + 20'd1;
                end
            end else begin
                r_db_cnt <= 20'd0;
            end
        end
    end

    // A press is the rising edge of the debounced level only.
    assign w_press = r_db_level & ~r_db_prev;

`ifdef DISPLAY_SCHEDULER_AUTO_ROTATE_EN
    logic [27:0] r_rot_cnt;

    assign w_rotate_expire = (r_state != S_FLASH) &&
                             (r_rot_cnt == ROTATE_CYCLES - 28'd1);

    // Rotate timer: restarts on any page change, frozen while flashing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rot_cnt <= 28'd0;
        end else if (w_next_state != r_state) begin
            r_rot_cnt <= 28'd0;
        end else if (r_state != S_FLASH) begin
            r_rot_cnt <= r_rot_cnt + 28'd1;
        end
    end
`else
    logic w_unused_rotate;

    assign w_rotate_expire = 1'b0;
    assign w_unused_rotate = ^ROTATE_CYCLES;
`endif

    // Next-state logic: syscall preemption outranks a press or rotation.
    always_comb begin
        w_next_state     = r_state;
        w_next_saved     = r_saved_page;
        w_next_flash_cnt = r_flash_cnt;
        if (r_state == S_FLASH) begin
            if (syscall_valid) begin
                w_next_flash_cnt = FLASH_CYCLES - 24'd1;
            end else if (w_press) begin
                w_next_state     = f_next_page(r_saved_page);
                w_next_flash_cnt = 24'd0;
            end else if (r_flash_cnt == 24'd0) begin
                w_next_state = r_saved_page;
            end else begin
                w_next_flash_cnt = r_flash_cnt - 24'd1;
            end
        end else begin
            if (syscall_valid) begin
                w_next_saved     = r_state;
                w_next_state     = S_FLASH;
                w_next_flash_cnt = FLASH_CYCLES - 24'd1;
            end else if (w_press || w_rotate_expire) begin
                w_next_state = f_next_page(r_state);
            end
        end
    end

    // State, saved page, flash timer and the transition pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_SYSCALL;
            r_saved_page <= S_SYSCALL;
            r_flash_cnt  <= 24'd0;
            page_changed <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_saved_page <= w_next_saved;
            r_flash_cnt  <= w_next_flash_cnt;
            page_changed <= (w_next_state != r_state);
        end
    end

    // Syscall value capture on its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syscall_reg <= 32'h0;
        end else if (syscall_valid) begin
            r_syscall_reg <= syscall_data;
        end
    end

    // Registered display mux, one cycle behind the page.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display_word <= 32'h0;
        end else begin
            case (r_state)
                S_CYCLES: display_word <= {20'b0, cycles_counter};
                S_PC:     display_word <= pc;
                default:  display_word <= r_syscall_reg;
            endcase
        end
    end

    assign page = r_state;

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_scheduler
//  Description : Self-checking bench for display_scheduler. Expected page
//                transitions are queued as stimulus is applied and popped on
//                each page_changed pulse; display/page values are checked
//                directly at known cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_display_scheduler;

    logic        clk;
    logic        rst_n;
    logic [31:0] syscall_data;
    logic        syscall_valid;
    logic [11:0] cycles_counter;
    logic [31:0] pc;
    logic        btn_next;
    logic [31:0] display_word;
    logic [1:0]  page;
    logic        page_changed;

    int          n_cmp;
    int          n_err;
    logic [1:0]  exp_q[$];
    logic [1:0]  mon_exp;

    display_scheduler #(
        .DEBOUNCE_CYCLES(20'd4),
        .FLASH_CYCLES   (24'd8),
        .ROTATE_CYCLES  (28'd16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .syscall_data  (syscall_data),
        .syscall_valid (syscall_valid),
        .cycles_counter(cycles_counter),
        .pc            (pc),
        .btn_next      (btn_next),
        .display_word  (display_word),
        .page          (page),
        .page_changed  (page_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Clean press: hold long enough to debounce, then release long enough.
    task automatic press(input logic [1:0] next_page);
        exp_q.push_back(next_page);
        btn_next = 1'b1;
        cyc(10);
        btn_next = 1'b0;
        cyc(10);
    endtask

    // Scoreboard: every page_changed pulse must match the next queued page.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && page_changed === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_err++;
                $error("FAIL page_changed_unexpected: observed page %0d expected no transition", page);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                n_cmp++;
                assert (page === mon_exp) else begin
                    n_err++;
                    $error("FAIL page_transition: observed %0d expected %0d", page, mon_exp);
                end
            end
        end
    end

    initial begin
        logic skip_rest;
        n_cmp          = 0;
        n_err          = 0;
        skip_rest      = 1'b0;
        rst_n          = 1'b0;
        btn_next       = 1'b0;
        syscall_valid  = 1'b0;
        syscall_data   = 32'h0;
        cycles_counter = 12'hABC;
        pc             = 32'hCAFE_0010;

        cyc(3);
        chk("reset_display", display_word, 32'h0);
        chk("reset_page", {30'd0, page}, 32'd0);
        chk("reset_page_changed", {31'd0, page_changed}, 32'd0);
        rst_n = 1'b1;

`ifdef DISPLAY_SCHEDULER_AUTO_ROTATE_EN
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        cyc(52);
        chk("rotate_all_seen", exp_q.size(), 32'd0);
        chk("rotate_page", {30'd0, page}, 32'd0);
        skip_rest = 1'b1;
`else
        cyc(48);
        chk("no_rotate_page", {30'd0, page}, 32'd0);
`endif

        if (!skip_rest) begin
            // Three clean presses around the ring.
            press(2'd1);
            chk("p1_page", {30'd0, page}, 32'd1);
            chk("p1_display", display_word, 32'h0000_0ABC);
            press(2'd2);
            chk("p2_page", {30'd0, page}, 32'd2);
            chk("p2_display", display_word, 32'hCAFE_0010);
            press(2'd0);
            chk("p3_page", {30'd0, page}, 32'd0);
            chk("p3_display", display_word, 32'h0);

            // Three-cycle glitch is rejected.
            btn_next = 1'b1;
            cyc(3);
            btn_next = 1'b0;
            cyc(10);
            chk("glitch_page", {30'd0, page}, 32'd0);

            // Long hold gives a single advance.
            exp_q.push_back(2'd1);
            btn_next = 1'b1;
            cyc(20);
            btn_next = 1'b0;
            cyc(10);
            chk("hold_page", {30'd0, page}, 32'd1);
            press(2'd2);

            // Syscall preemption from PC.
            syscall_data  = 32'h1234_5678;
            syscall_valid = 1'b1;
            exp_q.push_back(2'd3);
            exp_q.push_back(2'd2);
            for (int k = 1; k <= 10; k++) begin
                @(negedge clk);
                syscall_valid = 1'b0;
                if (k <= 8) chk($sformatf("flash_page_%0d", k), {30'd0, page}, 32'd3);
                if (k == 9) chk("flash_exit_page", {30'd0, page}, 32'd2);
                if (k >= 2 && k <= 9) chk($sformatf("flash_disp_%0d", k), display_word, 32'h1234_5678);
                if (k == 10) chk("flash_exit_disp", display_word, 32'hCAFE_0010);
            end

            // Reload inside FLASH extends it with no pulse; saved page CYCLES.
            press(2'd0);
            press(2'd1);
            syscall_data  = 32'h1111_2222;
            syscall_valid = 1'b1;
            exp_q.push_back(2'd3);
            exp_q.push_back(2'd1);
            for (int k = 1; k <= 14; k++) begin
                @(negedge clk);
                syscall_valid = 1'b0;
                if (k == 5) begin
                    syscall_data  = 32'hDEAD_BEEF;
                    syscall_valid = 1'b1;
                end
                if (k == 7)  chk("reload_disp", display_word, 32'hDEAD_BEEF);
                if (k == 13) chk("reload_extended_page", {30'd0, page}, 32'd3);
                if (k == 14) chk("reload_exit_page", {30'd0, page}, 32'd1);
            end
            cyc(2);

            // Press during FLASH leaves to the page after the saved one.
            syscall_data  = 32'h5555_AAAA;
            syscall_valid = 1'b1;
            btn_next      = 1'b1;
            exp_q.push_back(2'd3);
            exp_q.push_back(2'd2);
            @(negedge clk);
            syscall_valid = 1'b0;
            cyc(8);
            chk("flash_press_page", {30'd0, page}, 32'd2);
            btn_next = 1'b0;
            cyc(10);

            // Syscall and press on the same edge: syscall wins.
            press(2'd0);
            btn_next = 1'b1;
            cyc(6);
            syscall_data  = 32'h0BAD_F00D;
            syscall_valid = 1'b1;
            exp_q.push_back(2'd3);
            exp_q.push_back(2'd0);
            @(negedge clk);
            syscall_valid = 1'b0;
            chk("collide_page", {30'd0, page}, 32'd3);
            cyc(9);
            chk("collide_return_page", {30'd0, page}, 32'd0);
            btn_next = 1'b0;
            cyc(10);
            chk("collide_release_page", {30'd0, page}, 32'd0);

            // Reset in the middle of FLASH aborts it.
            syscall_data  = 32'h7777_8888;
            syscall_valid = 1'b1;
            exp_q.push_back(2'd3);
            @(negedge clk);
            syscall_valid = 1'b0;
            cyc(2);
            rst_n = 1'b0;
            #1;
            chk("rst_flash_page", {30'd0, page}, 32'd0);
            chk("rst_flash_display", display_word, 32'h0);
            chk("rst_flash_changed", {31'd0, page_changed}, 32'd0);
            cyc(2);
            rst_n = 1'b1;
            cyc(10);
            chk("post_rst_page", {30'd0, page}, 32'd0);
            chk("post_rst_display", display_word, 32'h0);
            chk("all_transitions_seen", exp_q.size(), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
